// File: rtl/ll_tx_frame_fifo_if.sv
`default_nettype none
// ==========================================================================
// ll_tx_frame_fifo_if: LocalLink ingress / EMAC client TX egress bundle
// Revision: 1.0
// ==========================================================================
interface ll_tx_frame_fifo_if #(
  parameter int FCNT_W = 4
);
  logic [7:0]        ll_data;
  logic              ll_sof;
  logic              ll_eof;
  logic              ll_src_rdy;
  logic              ll_dest_rdy;
  logic [7:0]        emac_tx_data;
  logic              emac_tx_data_valid;
  logic              emac_tx_ack;
  logic              frame_drop;
  logic [FCNT_W-1:0] frames_pending;

  modport master (
    output ll_data, ll_sof, ll_eof, ll_src_rdy, emac_tx_ack,
    input  ll_dest_rdy, emac_tx_data, emac_tx_data_valid, frame_drop, frames_pending
  );

  modport slave (
    input  ll_data, ll_sof, ll_eof, ll_src_rdy, emac_tx_ack,
    output ll_dest_rdy, emac_tx_data, emac_tx_data_valid, frame_drop, frames_pending
  );
endinterface
`default_nettype wire

// File: rtl/ll_tx_frame_fifo.sv
`default_nettype none
// ==========================================================================
// ll_tx_frame_fifo: store-and-forward frame FIFO, LocalLink in, EMAC TX out
// Revision: 1.0
// ==========================================================================
module ll_tx_frame_fifo #(
  parameter int ADDR_W = 11,
  parameter int FCNT_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  ll_tx_frame_fifo_if.slave bus
);
  localparam logic [ADDR_W:0]   DEPTH_P  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [FCNT_W-1:0] PEND_MAX = '1;

  localparam logic [1:0] W_IDLE   = 2'd0;
  localparam logic [1:0] W_FRAME  = 2'd1;
  localparam logic [1:0] W_DROP   = 2'd2;
  localparam logic [1:0] R_IDLE   = 2'd0;
  localparam logic [1:0] R_START  = 2'd1;
  localparam logic [1:0] R_STREAM = 2'd2;

  logic [8:0]        mem [2**ADDR_W];
  logic [ADDR_W:0]   wr_ptr, commit_ptr, rd_ptr;
  logic [ADDR_W:0]   wr_nxt, commit_nxt;
  logic [ADDR_W-1:0] waddr;
  logic [1:0]        wstate, wstate_nxt, rstate, rstate_nxt;
  logic [FCNT_W-1:0] pending;
  logic [7:0]        tx_byte;
  logic              tx_eof;
  logic              drop_q;
  logic              beat, full, commit_full, we, commit_inc, drop_now;
  logic              load, done;

  assign beat        = bus.ll_src_rdy && bus.ll_dest_rdy;
  assign full        = (wr_ptr - rd_ptr) == DEPTH_P;
  assign commit_full = (commit_ptr - rd_ptr) == DEPTH_P;

  always_comb begin
    wr_nxt     = wr_ptr;
    commit_nxt = commit_ptr;
    wstate_nxt = wstate;
    waddr      = wr_ptr[ADDR_W-1:0];
    we         = 1'b0;
    commit_inc = 1'b0;
    drop_now   = 1'b0;
    if (beat) begin
      if (bus.ll_sof) begin
        // An sof always restarts at the commit point, abandoning any open frame
        drop_now = (wstate == W_FRAME);
        if (commit_full) begin
          drop_now   = 1'b1;
          wr_nxt     = commit_ptr;
          wstate_nxt = bus.ll_eof ? W_IDLE : W_DROP;
        end else begin
          we     = 1'b1;
          waddr  = commit_ptr[ADDR_W-1:0];
          wr_nxt = commit_ptr + 1'b1;
          if (bus.ll_eof) begin
            commit_nxt = commit_ptr + 1'b1;
            commit_inc = 1'b1;
            wstate_nxt = W_IDLE;
          end else begin
            wstate_nxt = W_FRAME;
          end
        end
      end else if (wstate == W_FRAME) begin
        if (full) begin
          drop_now   = 1'b1;
          wr_nxt     = commit_ptr;
          wstate_nxt = bus.ll_eof ? W_IDLE : W_DROP;
        end else begin
          we     = 1'b1;
          wr_nxt = wr_ptr + 1'b1;
          if (bus.ll_eof) begin
            commit_nxt = wr_ptr + 1'b1;
            commit_inc = 1'b1;
            wstate_nxt = W_IDLE;
          end
        end
      end else if (wstate == W_DROP && bus.ll_eof) begin
        wstate_nxt = W_IDLE;
      end
    end
  end

  // tx_byte/tx_eof is the byte on the wire; rd_ptr already points past it
  always_comb begin
    rstate_nxt = rstate;
    load       = 1'b0;
    done       = 1'b0;
    case (rstate)
      R_IDLE: begin
        if (pending != '0) begin
          load       = 1'b1;
          rstate_nxt = R_START;
        end
      end
      R_START: begin
        if (bus.emac_tx_ack) begin
          if (tx_eof) begin
            done       = 1'b1;
            rstate_nxt = R_IDLE;
          end else begin
            load       = 1'b1;
            rstate_nxt = R_STREAM;
          end
        end
      end
      R_STREAM: begin
        if (tx_eof) begin
          done       = 1'b1;
          rstate_nxt = R_IDLE;
        end else begin
          load = 1'b1;
        end
      end
      default: rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      wstate     <= W_IDLE;
      rstate     <= R_IDLE;
      pending    <= '0;
      tx_byte    <= '0;
      tx_eof     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      wr_ptr     <= wr_nxt;
      commit_ptr <= commit_nxt;
      wstate     <= wstate_nxt;
      rstate     <= rstate_nxt;
      drop_q     <= drop_now;
      if (commit_inc && !done) begin
        pending <= pending + 1'b1;
      end else if (!commit_inc && done) begin
        pending <= pending - 1'b1;
      end
      if (load) begin
        {tx_eof, tx_byte} <= mem[rd_ptr[ADDR_W-1:0]];
        rd_ptr            <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= {bus.ll_eof, bus.ll_data};
    end
  end

  assign bus.ll_dest_rdy        = reset && (pending != PEND_MAX);
  assign bus.emac_tx_data       = tx_byte;
  assign bus.emac_tx_data_valid = (rstate != R_IDLE);
  assign bus.frame_drop         = drop_q;
  assign bus.frames_pending     = pending;
endmodule
`default_nettype wire

// File: tb/tb_ll_tx_frame_fifo.sv
`default_nettype none
// tb_ll_tx_frame_fifo: directed + randomized frames checked against a queue-based frame model.
module tb_ll_tx_frame_fifo;
  localparam int ADDR_W   = 11;
  localparam int FCNT_W   = 4;
  localparam int DEPTH    = 1 << ADDR_W;
  localparam int PEND_MAX = (1 << FCNT_W) - 1;
  localparam int M_IDLE   = 0;
  localparam int M_FRAME  = 1;
  localparam int M_DROP   = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ll_tx_frame_fifo_if #(.FCNT_W(FCNT_W)) bus ();

  ll_tx_frame_fifo #(.ADDR_W(ADDR_W), .FCNT_W(FCNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: committed frames as a flat byte queue plus a length queue
  logic [7:0] exp_bytes[$];
  int         exp_lens[$];
  logic [7:0] open_q[$];
  int  mode = M_IDLE;
  int  pos = 0;
  bit  tx_active = 0, gap_due = 0, start_due = 0, drop_exp = 0;
  int  rx_bytes = 0, rx_frames = 0, drops = 0, valid_cycles = 0;
  int  ack_delay = 3, ack_wait = 0;
  bit  ack_hold = 0, ack_noise = 0;

  always @(negedge clk) begin : monitor
    bit v;
    int pend_now, used_now, committed_now;
    if (!reset) begin
      exp_bytes.delete(); exp_lens.delete(); open_q.delete();
      mode = M_IDLE; pos = 0; tx_active = 0; gap_due = 0; start_due = 0; drop_exp = 0;
    end else begin
      pend_now      = exp_lens.size();
      committed_now = exp_bytes.size();
      used_now      = open_q.size() + committed_now;
      v             = bus.emac_tx_data_valid;
      check_eq("dest_rdy", bus.ll_dest_rdy, pend_now != PEND_MAX);
      check_eq("pending", bus.frames_pending, pend_now);
      check_eq("drop", bus.frame_drop, drop_exp);
      if (bus.frame_drop) drops++;
      if (tx_active)          check_eq("valid_mid", v, 1);
      else if (gap_due)       check_eq("gap", v, 0);
      else if (start_due)     check_eq("start", v, 1);
      else if (pend_now == 0) check_eq("spurious", v, 0);
      if (v && committed_now > 0) check_eq("data", bus.emac_tx_data, exp_bytes[0]);
      if (v) valid_cycles++;
      start_due = !v && !tx_active && pend_now > 0;
      gap_due   = 0;
      if (v && pend_now > 0 && (tx_active || bus.emac_tx_ack)) begin
        void'(exp_bytes.pop_front());
        pos++; rx_bytes++;
        if (pos == exp_lens[0]) begin
          void'(exp_lens.pop_front());
          pos = 0; tx_active = 0; gap_due = 1; rx_frames++;
        end else begin
          tx_active = 1;
        end
      end
      drop_exp = 0;
      if (bus.ll_src_rdy && pend_now != PEND_MAX) begin
        if (bus.ll_sof) begin
          drop_exp = (mode == M_FRAME);
          open_q.delete();
          if (committed_now == DEPTH) begin
            drop_exp = 1;
            mode = bus.ll_eof ? M_IDLE : M_DROP;
          end else begin
            open_q.push_back(bus.ll_data);
            mode = M_FRAME;
          end
        end else if (mode == M_FRAME) begin
          if (used_now == DEPTH) begin
            drop_exp = 1;
            open_q.delete();
            mode = bus.ll_eof ? M_IDLE : M_DROP;
          end else begin
            open_q.push_back(bus.ll_data);
          end
        end else if (mode == M_DROP && bus.ll_eof) begin
          mode = M_IDLE;
        end
        if (mode == M_FRAME && bus.ll_eof) begin
          foreach (open_q[i]) exp_bytes.push_back(open_q[i]);
          exp_lens.push_back(open_q.size());
          open_q.delete();
          mode = M_IDLE;
        end
      end
    end
  end

  // EMAC side: ack the first byte after ack_delay cycles; optional stray acks elsewhere
  always @(posedge clk) begin
    #1;
    if (bus.emac_tx_data_valid === 1'b1 && !tx_active) begin
      bus.emac_tx_ack = !ack_hold && (ack_wait >= ack_delay);
      ack_wait++;
    end else begin
      ack_wait = 0;
      bus.emac_tx_ack = ack_noise && ($urandom_range(3) == 0);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put_beat(input logic [7:0] d, input bit s, input bit e);
    int guard = 0;
    bit acc = 0;
    bus.ll_data = d; bus.ll_sof = s; bus.ll_eof = e; bus.ll_src_rdy = 1'b1;
    while (!acc && guard < 3000) begin
      @(negedge clk);
      acc = bus.ll_dest_rdy;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) check_eq("beat_accept", acc, 1);
    bus.ll_src_rdy = 1'b0;
  endtask

  task automatic send_frame(input int len, input logic [7:0] base, input bit incr, input int max_gap);
    for (int i = 0; i < len; i++) begin
      put_beat(incr ? 8'(base + i) : 8'($urandom), i == 0, i == len - 1);
      if (max_gap > 0) idle($urandom_range(max_gap));
    end
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((exp_lens.size() != 0 || tx_active) && guard < 20000) begin
      idle(1);
      guard++;
    end
    check_eq("drain", exp_lens.size(), 0);
    idle(3);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0, f0, d0, v0, g;
    bus.ll_data = '0; bus.ll_sof = 1'b0; bus.ll_eof = 1'b0; bus.ll_src_rdy = 1'b0;
    idle(3);
    check_eq("rst_dest_rdy", bus.ll_dest_rdy, 0);
    check_eq("rst_valid", bus.emac_tx_data_valid, 0);
    check_eq("rst_data", bus.emac_tx_data, 0);
    check_eq("rst_pending", bus.frames_pending, 0);
    check_eq("rst_drop", bus.frame_drop, 0);
    reset = 1'b1;
    idle(2);

    // 12-byte frame, ack 3 cycles after valid
    ack_delay = 3; r0 = rx_bytes; d0 = drops;
    send_frame(12, 8'hE0, 1, 0);
    wait_drain();
    check_eq("t1_bytes", rx_bytes - r0, 12);
    check_eq("t1_drops", drops - d0, 0);

    // three 64-byte frames back to back
    ack_delay = 5; r0 = rx_bytes; f0 = rx_frames; d0 = drops;
    for (int k = 0; k < 3; k++) send_frame(64, 8'(k * 64), 1, 0);
    wait_drain();
    check_eq("t2_bytes", rx_bytes - r0, 192);
    check_eq("t2_frames", rx_frames - f0, 3);
    check_eq("t2_drops", drops - d0, 0);

    // oversize frame overflows the buffer, the next frame survives
    ack_delay = 1; r0 = rx_bytes; f0 = rx_frames; d0 = drops;
    send_frame(DEPTH + 6, 8'h00, 1, 0);
    send_frame(8, 8'hC0, 1, 0);
    wait_drain();
    check_eq("t3_drops", drops - d0, 1);
    check_eq("t3_bytes", rx_bytes - r0, 8);
    check_eq("t3_frames", rx_frames - f0, 1);

    // sof inside an open frame aborts it
    r0 = rx_bytes; d0 = drops;
    for (int i = 0; i < 4; i++) put_beat(8'(8'h10 + i), i == 0, 1'b0);
    send_frame(4, 8'hA0, 1, 0);
    wait_drain();
    check_eq("t4_drops", drops - d0, 1);
    check_eq("t4_bytes", rx_bytes - r0, 4);

    // single-byte frame, immediate ack
    ack_delay = 0; r0 = rx_bytes; v0 = valid_cycles;
    put_beat(8'h55, 1'b1, 1'b1);
    wait_drain();
    check_eq("t5_valid_cycles", valid_cycles - v0, 1);
    check_eq("t5_bytes", rx_bytes - r0, 1);

    // reset in the middle of streaming
    ack_delay = 2;
    send_frame(20, 8'h30, 1, 0);
    g = 0;
    while (!(tx_active && pos >= 5) && g < 300) begin idle(1); g++; end
    check_eq("t6_streaming", tx_active, 1);
    reset = 1'b0;
    #1;
    check_eq("t6_valid", bus.emac_tx_data_valid, 0);
    check_eq("t6_pending", bus.frames_pending, 0);
    check_eq("t6_dest_rdy", bus.ll_dest_rdy, 0);
    check_eq("t6_data", bus.emac_tx_data, 0);
    idle(3);
    reset = 1'b1;
    idle(2);
    r0 = rx_bytes;
    send_frame(10, 8'h70, 1, 0);
    wait_drain();
    check_eq("t6_after_bytes", rx_bytes - r0, 10);

    // pending-frame limit back-pressures the source
    ack_hold = 1;
    for (int k = 0; k < PEND_MAX; k++) send_frame(3, 8'(k * 3), 1, 0);
    idle(2);
    check_eq("max_pending", bus.frames_pending, PEND_MAX);
    check_eq("max_dest_rdy", bus.ll_dest_rdy, 0);
    ack_hold = 0;
    wait_drain();

    // randomized traffic with aborts, stray beats and stray acks
    ack_noise = 1;
    for (int k = 0; k < 60; k++) begin
      ack_delay = $urandom_range(6);
      if ($urandom_range(9) == 0) begin
        int n = $urandom_range(1, 5);
        for (int i = 0; i < n; i++) put_beat(8'($urandom), i == 0, 1'b0);
      end
      if ($urandom_range(7) == 0) put_beat(8'($urandom), 1'b0, 1'($urandom));
      send_frame($urandom_range(1, 40), 8'h00, 0, 2);
      idle($urandom_range(3));
    end
    wait_drain();
    ack_noise = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
